ppu_vram_arb: RTL and testbench
===============================

# ppu_vram_arb

Multi-cycle arbiter and sequencer for the PPU's single external video memory port. It shares the 14-bit VRAM bus between three requesters: the sprite fetcher, the background fetcher and the register interface (CPU $2007 traffic). For each granted request it drives one registered access, waits the memory read latency, then returns data and a one-cycle acknowledge. It replaces the combinational sprite/background address mux at the PPU top level.

## Interface
Parameters:
- RD_LAT, default 1: cycles from vram_a_out valid to vram_d_in valid. Legal range is 1–4.
- STARVE_LIM, default 8: number of waiting cycles after which a register-interface request is promoted. Used only when the configuration macro is defined.

Ports:
- clk_in  in  1  100 MHz system clock; all state changes on its rising edge
- rst_n_in  in  1  reset; asynchronous assertion, active-low
- spr_req_in  in  1  sprite fetch request, level, held until spr_ack_out
- spr_a_in  in  14  sprite fetch address
- spr_ack_out  out  1  one-cycle pulse; rd_d_out is valid in the same cycle
- bg_req_in  in  1  background fetch request, level
- bg_a_in  in  14  background fetch address
- bg_ack_out  out  1  one-cycle pulse
- ri_req_in  in  1  register-interface request, level
- ri_wr_in  in  1  1 = write, 0 = read
- ri_a_in  in  14  register-interface address
- ri_d_in  in  8  register-interface write data
- ri_ack_out  out  1  one-cycle pulse
- rd_d_out  out  8  read data, shared by all requesters
- vram_a_out  out  14  VRAM address, registered
- vram_d_out  out  8  VRAM write data, registered
- vram_wr_out  out  1  VRAM write strobe, registered
- vram_d_in  in  8  VRAM read data
- busy_out  out  1  high in every state except IDLE

## Operation
The state machine has four states: IDLE, ADDR, WAIT and ACK.

**IDLE**
- Samples the three requests.
- Fixed priority is spr > bg > ri.
- Latches the winner's owner id, address, wr and data, then goes to ADDR.
- With no request pending, it stays in IDLE.

**ADDR** (one cycle)
- vram_a_out shows the latched address.
- For a write, vram_wr_out is 1 and vram_d_out shows the latched data.
- A write goes to ACK. A read goes to WAIT.

**WAIT** (RD_LAT cycles)
- A latency counter counts down.
- On the final WAIT cycle, vram_d_in is registered into rd_d_out, and the state goes to ACK.

**ACK** (one cycle)
- Exactly one of the three ack outputs is high, selected by owner, then the state returns to IDLE.
- The requester must deassert its req in the cycle after the ack unless it is issuing a new access. A req still high in IDLE is treated as a new request.

Data and output rules:
- Only the register interface can write. spr and bg accesses are always reads.
- A write ack leaves rd_d_out unchanged.
- vram_a_out holds its last value while idle.
- vram_wr_out is 0 in every state except a write ADDR cycle.

Request rules:
- Requests are sampled only in IDLE.
- Changing a request's address or data, or withdrawing it, between assertion and its ack is a protocol violation. The arbiter behaviour is then unspecified, but it must still return to IDLE.

Boundary and reset behaviour:
- All three requests in the same IDLE cycle: spr wins; bg and ri wait and are served in later passes through IDLE.
- Addresses are passed through unmodified; no masking or wrap is applied.
- Reset values: state IDLE, all acks 0, rd_d_out 0x00, vram_a_out 0x0000, vram_d_out 0x00, vram_wr_out 0, busy_out 0, latency and starvation counters 0.
- Reset asserted mid-access aborts the access immediately. No ack is ever issued for the aborted request.

## Timing
Cycle 0 is the IDLE cycle in which the request is sampled.
- Read: vram_a_out is valid in cycle 1. vram_d_in is sampled in cycle 1+RD_LAT. The ack and rd_d_out appear in cycle 2+RD_LAT, which is cycle 3 when RD_LAT is 1.
- Write: vram_wr_out is high in cycle 1 only. The ack is in cycle 2.
- Back-to-back throughput:
  - Reads: one access per 3+RD_LAT cycles.
  - Writes: one access per 3 cycles.
- busy_out is registered. It rises in cycle 1 and falls in the cycle after the ack.

## Configuration
- PPU_VRAM_ARB_STARVE_GUARD_EN **defined**:
  - A saturating counter increments every cycle in which ri_req_in is high and the register interface is not the owner.
  - When the counter equals STARVE_LIM, the register interface wins the next IDLE arbitration over spr and bg.
  - The counter clears when the register interface is granted.
- PPU_VRAM_ARB_STARVE_GUARD_EN **undefined**:
  - Strict spr > bg > ri priority.
  - The counter logic is absent.

## Test plan
- bg read at 0x2000 with RD_LAT=1 and memory returning 0x5A: vram_a_out=0x2000 in cycle 1; bg_ack_out pulses in cycle 3 with rd_d_out=0x5A; no other ack fires.
- ri write of 0x3C to 0x23C0: vram_wr_out=1 for exactly one cycle (cycle 1) with vram_d_out=0x3C; ri_ack_out in cycle 2; rd_d_out is unchanged.
- spr, bg and ri requests raised together and each held until its own ack: acks arrive in the order spr, bg, ri, with 4 cycles between read acks at RD_LAT=1.
- With the macro defined and STARVE_LIM=8: bg held continuously with a new address each access, plus ri raised → ri_ack_out arrives within 8 + 2×(3+RD_LAT) cycles. With the macro undefined, ri is never acked until bg drops.
- rst_n_in pulled low in cycle 2 of a read: all outputs are at reset values within the same cycle; no ack occurs after release; the next request is served normally.
- RD_LAT=4 with a spr read of 0x1FF0: spr_ack_out in cycle 6, and busy_out high in cycles 1–6.

Source files
------------

// File: rtl/ppu_vram_arb.sv
// Arbiter/sequencer for the PPU's single VRAM port: spr > bg > ri fixed priority,
// one registered access per grant. Optional ri starvation guard: PPU_VRAM_ARB_STARVE_GUARD_EN.
module ppu_vram_arb #(
    parameter int RD_LAT     = 1,
    parameter int STARVE_LIM = 8
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        spr_req_in,
    input  logic [13:0] spr_a_in,
    output logic        spr_ack_out,
    input  logic        bg_req_in,
    input  logic [13:0] bg_a_in,
    output logic        bg_ack_out,
    input  logic        ri_req_in,
    input  logic        ri_wr_in,
    input  logic [13:0] ri_a_in,
    input  logic [7:0]  ri_d_in,
    output logic        ri_ack_out,
    output logic [7:0]  rd_d_out,
    output logic [13:0] vram_a_out,
    output logic [7:0]  vram_d_out,
    output logic        vram_wr_out,
    input  logic [7:0]  vram_d_in,
    output logic        busy_out
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_ACK  = 2'd3;

    localparam logic [1:0] OWN_SPR = 2'd0;
    localparam logic [1:0] OWN_BG  = 2'd1;
    localparam logic [1:0] OWN_RI  = 2'd2;

    localparam int LAT_W = 3;

    logic [1:0]       state_q, state_d;
    logic [1:0]       owner_q, owner_d;
    logic             wr_q, wr_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [13:0]      vram_a_q, vram_a_d;
    logic [7:0]       vram_d_q, vram_d_d;
    logic             vram_wr_q, vram_wr_d;
    logic [7:0]       rd_d_q, rd_d_d;
    logic             spr_ack_q, spr_ack_d;
    logic             bg_ack_q, bg_ack_d;
    logic             ri_ack_q, ri_ack_d;
    logic             busy_q, busy_d;

    logic             starve_hit;
    logic             ri_granted;

`ifdef PPU_VRAM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIM + 1);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             ri_is_owner;

    assign ri_is_owner = (state_q != ST_IDLE) && (owner_q == OWN_RI);
    assign starve_hit  = (starve_cnt_q == CNT_W'(STARVE_LIM));

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (ri_granted) begin
            starve_cnt_d = '0;
        end else if (ri_req_in && !ri_is_owner && !starve_hit) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    // Guard disabled: constant-false promotion keeps strict priority.
    assign starve_hit = (STARVE_LIM < 0);
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        wr_d       = wr_q;
        lat_d      = lat_q;
        vram_a_d   = vram_a_q;
        vram_d_d   = vram_d_q;
        vram_wr_d  = 1'b0;
        rd_d_d     = rd_d_q;
        ri_granted = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A promoted ri overrides the fixed order for one arbitration.
                if (ri_req_in && starve_hit) begin
                    owner_d    = OWN_RI;
                    ri_granted = 1'b1;
                end else if (spr_req_in) begin
                    owner_d = OWN_SPR;
                end else if (bg_req_in) begin
                    owner_d = OWN_BG;
                end else if (ri_req_in) begin
                    owner_d    = OWN_RI;
                    ri_granted = 1'b1;
                end

                if (spr_req_in || bg_req_in || ri_req_in) begin
                    state_d = ST_ADDR;
                    wr_d    = ri_granted && ri_wr_in;
                    case (owner_d)
                        OWN_SPR: vram_a_d = spr_a_in;
                        OWN_BG:  vram_a_d = bg_a_in;
                        default: vram_a_d = ri_a_in;
                    endcase
                    if (ri_granted && ri_wr_in) begin
                        vram_d_d  = ri_d_in;
                        vram_wr_d = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                if (wr_q) begin
                    state_d = ST_ACK;
                end else begin
                    state_d = ST_WAIT;
                    lat_d   = LAT_W'(RD_LAT - 1);
                end
            end
            ST_WAIT: begin
                if (lat_q == '0) begin
                    rd_d_d  = vram_d_in;
                    state_d = ST_ACK;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        spr_ack_d = (state_d == ST_ACK) && (owner_q == OWN_SPR);
        bg_ack_d  = (state_d == ST_ACK) && (owner_q == OWN_BG);
        ri_ack_d  = (state_d == ST_ACK) && (owner_q == OWN_RI);
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_SPR;
            wr_q      <= 1'b0;
            lat_q     <= '0;
            vram_a_q  <= '0;
            vram_d_q  <= '0;
            vram_wr_q <= 1'b0;
            rd_d_q    <= '0;
            spr_ack_q <= 1'b0;
            bg_ack_q  <= 1'b0;
            ri_ack_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            wr_q      <= wr_d;
            lat_q     <= lat_d;
            vram_a_q  <= vram_a_d;
            vram_d_q  <= vram_d_d;
            vram_wr_q <= vram_wr_d;
            rd_d_q    <= rd_d_d;
            spr_ack_q <= spr_ack_d;
            bg_ack_q  <= bg_ack_d;
            ri_ack_q  <= ri_ack_d;
            busy_q    <= busy_d;
        end
    end

    assign spr_ack_out = spr_ack_q;
    assign bg_ack_out  = bg_ack_q;
    assign ri_ack_out  = ri_ack_q;
    assign rd_d_out    = rd_d_q;
    assign vram_a_out  = vram_a_q;
    assign vram_d_out  = vram_d_q;
    assign vram_wr_out = vram_wr_q;
    assign busy_out    = busy_q;

endmodule

// File: tb/tb_ppu_vram_arb.sv
// Directed bench for ppu_vram_arb: one RD_LAT=1 instance, one RD_LAT=4 instance.
module tb_ppu_vram_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        spr_req = 1'b0, bg_req = 1'b0, ri_req = 1'b0, ri_wr = 1'b0;
    logic [13:0] spr_a = '0, bg_a = '0, ri_a = '0;
    logic [7:0]  ri_d = '0;
    logic        spr_ack, bg_ack, ri_ack, vram_wr, busy;
    logic [7:0]  rd_d, vram_d, vram_din;
    logic [13:0] vram_a;

    logic        s4_req = 1'b0;
    logic [13:0] s4_a = '0;
    logic        s4_spr_ack, s4_bg_ack, s4_ri_ack, s4_vram_wr, s4_busy;
    logic [7:0]  s4_rd_d, s4_vram_d, s4_vram_din;
    logic [13:0] s4_vram_a;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Memory model: data derived from the address, combinational.
    function automatic logic [7:0] mem_f(input logic [13:0] a);
        return a[7:0] ^ {2'b00, a[13:8]} ^ 8'h7A;
    endfunction

    assign vram_din    = mem_f(vram_a);
    assign s4_vram_din = mem_f(s4_vram_a);

    ppu_vram_arb #(.RD_LAT(1), .STARVE_LIM(8)) u1 (
        .clk_in(clk), .rst_n_in(rst_n),
        .spr_req_in(spr_req), .spr_a_in(spr_a), .spr_ack_out(spr_ack),
        .bg_req_in(bg_req), .bg_a_in(bg_a), .bg_ack_out(bg_ack),
        .ri_req_in(ri_req), .ri_wr_in(ri_wr), .ri_a_in(ri_a), .ri_d_in(ri_d),
        .ri_ack_out(ri_ack), .rd_d_out(rd_d), .vram_a_out(vram_a),
        .vram_d_out(vram_d), .vram_wr_out(vram_wr), .vram_d_in(vram_din),
        .busy_out(busy)
    );

    ppu_vram_arb #(.RD_LAT(4), .STARVE_LIM(8)) u4 (
        .clk_in(clk), .rst_n_in(rst_n),
        .spr_req_in(s4_req), .spr_a_in(s4_a), .spr_ack_out(s4_spr_ack),
        .bg_req_in(1'b0), .bg_a_in(14'h0), .bg_ack_out(s4_bg_ack),
        .ri_req_in(1'b0), .ri_wr_in(1'b0), .ri_a_in(14'h0), .ri_d_in(8'h0),
        .ri_ack_out(s4_ri_ack), .rd_d_out(s4_rd_d), .vram_a_out(s4_vram_a),
        .vram_d_out(s4_vram_d), .vram_wr_out(s4_vram_wr), .vram_d_in(s4_vram_din),
        .busy_out(s4_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int spr_c, bg_c, ri_c, drop_c, acks;
        logic [7:0] spr_v, bg_v, ri_v;

        // Reset values
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_acks", 32'({spr_ack, bg_ack, ri_ack}), 32'd0);
        chk("rst_rd_d", 32'(rd_d), 32'h00);
        chk("rst_vram_a", 32'(vram_a), 32'h0000);
        chk("rst_vram_d", 32'(vram_d), 32'h00);
        chk("rst_vram_wr", 32'(vram_wr), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // bg read at 0x2000
        bg_req = 1'b1; bg_a = 14'h2000;
        tick();
        chk("bg_c1_addr", 32'(vram_a), 32'h2000);
        chk("bg_c1_busy", 32'(busy), 32'd1);
        chk("bg_c1_wr", 32'(vram_wr), 32'd0);
        chk("bg_c1_acks", 32'({spr_ack, bg_ack, ri_ack}), 32'd0);
        tick();
        chk("bg_c2_acks", 32'({spr_ack, bg_ack, ri_ack}), 32'd0);
        tick();
        chk("bg_c3_acks", 32'({spr_ack, bg_ack, ri_ack}), 32'b010);
        chk("bg_c3_rd_d", 32'(rd_d), 32'h5A);
        bg_req = 1'b0;
        tick();
        chk("bg_c4_acks", 32'({spr_ack, bg_ack, ri_ack}), 32'd0);
        chk("bg_c4_busy", 32'(busy), 32'd0);

        // ri write 0x3C to 0x23C0
        ri_req = 1'b1; ri_wr = 1'b1; ri_a = 14'h23C0; ri_d = 8'h3C;
        tick();
        chk("wr_c1_wr", 32'(vram_wr), 32'd1);
        chk("wr_c1_d", 32'(vram_d), 32'h3C);
        chk("wr_c1_addr", 32'(vram_a), 32'h23C0);
        chk("wr_c1_ack", 32'(ri_ack), 32'd0);
        tick();
        chk("wr_c2_wr", 32'(vram_wr), 32'd0);
        chk("wr_c2_acks", 32'({spr_ack, bg_ack, ri_ack}), 32'b001);
        chk("wr_c2_rd_d", 32'(rd_d), 32'h5A);
        ri_req = 1'b0; ri_wr = 1'b0;
        tick();
        chk("wr_c3_busy", 32'(busy), 32'd0);
        chk("wr_c3_addr_hold", 32'(vram_a), 32'h23C0);

        // All three together, each held until its own ack
        spr_req = 1'b1; spr_a = 14'h0100;
        bg_req = 1'b1;  bg_a = 14'h0200;
        ri_req = 1'b1;  ri_a = 14'h0300;
        spr_c = -1; bg_c = -1; ri_c = -1; acks = 0;
        spr_v = '0; bg_v = '0; ri_v = '0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (32'(spr_ack) + 32'(bg_ack) + 32'(ri_ack) > 1) acks++;
            if (spr_ack) begin spr_c = c; spr_v = rd_d; spr_req = 1'b0; end
            if (bg_ack)  begin bg_c = c;  bg_v = rd_d;  bg_req = 1'b0; end
            if (ri_ack)  begin ri_c = c;  ri_v = rd_d;  ri_req = 1'b0; end
        end
        chk("all3_spr_cyc", 32'(spr_c), 32'd3);
        chk("all3_bg_cyc", 32'(bg_c), 32'd7);
        chk("all3_ri_cyc", 32'(ri_c), 32'd11);
        chk("all3_spr_data", 32'(spr_v), 32'h7B);
        chk("all3_bg_data", 32'(bg_v), 32'h78);
        chk("all3_ri_data", 32'(ri_v), 32'h79);
        chk("all3_multi_ack", 32'(acks), 32'd0);

        // bg held continuously with fresh addresses, ri read pending
        bg_req = 1'b1; bg_a = 14'h0400;
        ri_req = 1'b1; ri_wr = 1'b0; ri_a = 14'h0333;
        ri_c = -1; drop_c = -1; ri_v = '0;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (bg_ack) begin
                if (c >= 30) begin bg_req = 1'b0; drop_c = c; end
                else bg_a = bg_a + 14'd1;
            end
            if (ri_ack) begin
                if (ri_c < 0) begin ri_c = c; ri_v = rd_d; end
                ri_req = 1'b0;
            end
        end
        chk("starve_bg_dropped", 32'(drop_c > 0), 32'd1);
        chk("starve_ri_acked", 32'(ri_c > 0), 32'd1);
        chk("starve_ri_data", 32'(ri_v), 32'h4A);
`ifdef PPU_VRAM_ARB_STARVE_GUARD_EN
        chk("starve_ri_bound", 32'(ri_c <= 16), 32'd1);
`else
        chk("starve_ri_after_bg", 32'(ri_c > drop_c), 32'd1);
`endif
        tick();
        chk("starve_idle", 32'(busy), 32'd0);

        // Reset in cycle 2 of a read
        spr_req = 1'b1; spr_a = 14'h0555;
        tick();
        tick();
        rst_n = 1'b0;
        spr_req = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_acks", 32'({spr_ack, bg_ack, ri_ack}), 32'd0);
        chk("arst_vram_a", 32'(vram_a), 32'h0000);
        chk("arst_rd_d", 32'(rd_d), 32'h00);
        chk("arst_vram_wr_d", 32'({vram_wr, vram_d}), 32'h000);
        tick();
        rst_n = 1'b1;
        acks = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (spr_ack || bg_ack || ri_ack || busy) acks++;
        end
        chk("arst_no_ack", 32'(acks), 32'd0);
        bg_req = 1'b1; bg_a = 14'h2000;
        tick();
        chk("arst_next_addr", 32'(vram_a), 32'h2000);
        tick();
        tick();
        chk("arst_next_ack", 32'({spr_ack, bg_ack, ri_ack}), 32'b010);
        chk("arst_next_data", 32'(rd_d), 32'h5A);
        bg_req = 1'b0;
        tick();

        // RD_LAT=4 spr read of 0x1FF0
        s4_req = 1'b1; s4_a = 14'h1FF0;
        spr_c = -1; acks = 0; spr_v = '0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (s4_busy !== ((c >= 1) && (c <= 6))) acks++;
            if (s4_spr_ack) begin spr_c = c; spr_v = s4_rd_d; s4_req = 1'b0; end
        end
        chk("lat4_ack_cyc", 32'(spr_c), 32'd6);
        chk("lat4_data", 32'(spr_v), 32'h95);
        chk("lat4_busy_bad", 32'(acks), 32'd0);
        chk("lat4_addr", 32'(s4_vram_a), 32'h1FF0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
